// File: rtl/bit_serial_alu_seq_pkg.sv
// bit_serial_alu_seq_pkg: op encodings and sequencer states shared by the bit-serial ALU
package bit_serial_alu_seq_pkg;
  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_ADD  = 2'd2;
  localparam logic [1:0] OP_PASS = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
endpackage

// File: rtl/bit_serial_alu_seq_slice.sv
// alu_slice_1b: combinational 1-bit ALU slice (AND/OR/add/pass-src2) with B_invert and carry chain
module alu_slice_1b
  import bit_serial_alu_seq_pkg::*;
(
  input  logic       src1_i,
  input  logic       src2_i,
  input  logic       b_invert_i,
  input  logic       cin_i,
  input  logic [1:0] op_i,
  output logic       result_o,
  output logic       cout_o
);
  logic b_add;
  logic sum;
  assign b_add    = src2_i ^ b_invert_i;
  assign sum      = src1_i ^ b_add ^ cin_i;
  assign cout_o   = (op_i == OP_ADD) & ((src1_i & b_add) | (cin_i & (src1_i ^ b_add)));
  assign result_o = (op_i == OP_AND) ? (src1_i & src2_i) :
                    (op_i == OP_OR)  ? (src1_i | src2_i) :
                    (op_i == OP_ADD) ? sum : src2_i;
endmodule

// File: rtl/bit_serial_alu_seq.sv
// bit_serial_alu_seq: feeds a 1-bit ALU slice LSB-first across a WIDTH-bit word, one bit per clock
module bit_serial_alu_seq
  import bit_serial_alu_seq_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             b_invert_i,
  input  logic [1:0]       op_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q, result_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic             binv_q, carry_q, cin_msb_q, cout_fin_q;
  logic             busy_q, done_q, zero_q, cout_q, ovf_q;
  logic             s_res, s_cout, accept, last;
  // busy is registered, so IDLE only accepts once the previous DONE has drained out of busy
  assign accept = (state_q == ST_IDLE) & ~busy_q & start_i;
  assign last   = cnt_q == CNT_W'(WIDTH - 1);
  alu_slice_1b u_slice (
    .src1_i     (a_q[0]),
    .src2_i     (b_q[0]),
    .b_invert_i (binv_q),
    .cin_i      (carry_q),
    .op_i       (op_q),
    .result_o   (s_res),
    .cout_o     (s_cout)
  );
  always_comb begin
    state_d = state_q;
    if (accept) state_d = ST_RUN;
    else if (state_q == ST_RUN && last) state_d = ST_DONE;
    else if (state_q == ST_DONE) state_d = ST_IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      op_q       <= OP_AND;
      binv_q     <= 1'b0;
      carry_q    <= 1'b0;
      cin_msb_q  <= 1'b0;
      cout_fin_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      zero_q     <= 1'b0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= state_q != ST_IDLE;
      done_q  <= state_q == ST_DONE;
      if (accept) begin
        a_q     <= src1_i;
        b_q     <= src2_i;
        op_q    <= op_i;
        binv_q  <= b_invert_i;
        carry_q <= (op_i == OP_ADD) & b_invert_i;
        cnt_q   <= '0;
      end else if (state_q == ST_RUN) begin
        a_q     <= a_q >> 1;
        b_q     <= b_q >> 1;
        res_q   <= {s_res, res_q[WIDTH-1:1]};
        carry_q <= s_cout;
        cnt_q   <= cnt_q + CNT_W'(1);
        if (last) begin
          cin_msb_q  <= carry_q;
          cout_fin_q <= s_cout;
        end
      end else if (state_q == ST_DONE) begin
        result_q <= res_q;
        zero_q   <= res_q == '0;
        cout_q   <= (op_q == OP_ADD) & cout_fin_q;
        ovf_q    <= (op_q == OP_ADD) & (cin_msb_q ^ cout_fin_q);
      end
    end
  end
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign zero_o     = zero_q;
  assign cout_o     = cout_q;
  assign overflow_o = ovf_q;
endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// tb_bit_serial_alu_seq: table vectors, random ops against an arithmetic model, and handshake/reset sequences
module tb_bit_serial_alu_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src1 = '0, src2 = '0;
  logic        binv = 1'b0;
  logic [1:0]  op = 2'd0;
  logic        busy, done, zero, cout, ovf;
  logic [31:0] result;
  int checks = 0, failures = 0;

  bit_serial_alu_seq #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .src1_i(src1), .src2_i(src2),
    .b_invert_i(binv), .op_i(op), .busy_o(busy), .done_o(done), .result_o(result),
    .zero_o(zero), .cout_o(cout), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b;
    logic [1:0]  op;
    logic        binv;
    logic [31:0] res;
    logic        z, c, v;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Plain arithmetic reference: {overflow, cout, zero, result}
  function automatic logic [34:0] model(input logic [31:0] a, b, input logic [1:0] o, input logic bi);
    logic [32:0] s;
    logic [31:0] bb, r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    bb = bi ? ~b : b;
    s = {1'b0, a} + {1'b0, bb} + {32'd0, bi};
    r = (o == 2'd0) ? (a & b) : (o == 2'd1) ? (a | b) : (o == 2'd2) ? s[31:0] : b;
    if (o == 2'd2) begin
      c = s[32];
      v = (a[31] == bb[31]) && (r[31] != a[31]);
    end
    return {v, c, (r == 32'd0), r};
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!busy && !done) return;
      @(posedge clk); #1;
    end
    check("idle_timeout", 1, 0);
  endtask

  task automatic do_op(input logic [31:0] a, b, input logic [1:0] o, input logic bi, output int lat);
    wait_idle();
    src1 = a; src2 = b; op = o; binv = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    check("done_seen", lat != 0, 1);
  endtask

  task automatic check_outs(input string name, input logic [34:0] exp);
    check({name, "_res"}, result, exp[31:0]);
    check({name, "_zero"}, zero, exp[32]);
    check({name, "_cout"}, cout, exp[33]);
    check({name, "_ovf"}, ovf, exp[34]);
  endtask

  initial begin
    vec_t vecs[8];
    int lat, t0, ndone;
    int tdone[$];
    logic [31:0] ra, rb;
    logic [1:0]  ro;
    logic        rbi;
    logic [34:0] exp;
    vecs[0] = '{32'd5, 32'd3, 2'd2, 1'b0, 32'h00000008, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'd3, 32'd5, 2'd2, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'hFFFFFFFF, 32'd1, 2'd2, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{32'h7FFFFFFF, 32'd1, 2'd2, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'hF0F0F0F0, 32'hFF00FF00, 2'd0, 1'b1, 32'hF000F000, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'hF0F0F0F0, 32'hFF00FF00, 2'd1, 1'b1, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'hF0F0F0F0, 32'hFF00FF00, 2'd3, 1'b1, 32'hFF00FF00, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'h80000000, 32'd1, 2'd2, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};

    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check_outs("rst", 35'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].binv, lat);
      if (i == 0) check("latency", lat, 33);
      check_outs($sformatf("vec%0d", i), {vecs[i].v, vecs[i].c, vecs[i].z, vecs[i].res});
      check("busy_in_done", busy, 1);
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
    end
    repeat (5) @(posedge clk);
    #1 check("hold_res", result, vecs[7].res);

    for (int i = 0; i < 30; i++) begin
      ra = $urandom; rb = $urandom; ro = 2'($urandom_range(0, 3)); rbi = 1'($urandom_range(0, 1));
      if (i < 4) rb = ~ra + 32'(i);
      do_op(ra, rb, ro, rbi, lat);
      check_outs($sformatf("rnd%0d", i), model(ra, rb, ro, rbi));
    end

    // Operands and controls changed mid-RUN must not disturb the op in flight
    wait_idle();
    src1 = 32'h12345678; src2 = 32'h0FEDCBA9; op = 2'd2; binv = 1'b1; start = 1'b1;
    exp = model(32'h12345678, 32'h0FEDCBA9, 2'd2, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    src1 = $urandom; src2 = $urandom; op = 2'd1; binv = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    check("midrun_done", lat != 0, 1);
    check_outs("midrun", exp);

    // start held high: back-to-back ops spaced 35 cycles apart
    wait_idle();
    src1 = 32'd100; src2 = 32'd23; op = 2'd2; binv = 1'b0; start = 1'b1;
    t0 = 0;
    for (int k = 0; k < 110; k++) begin
      @(posedge clk); #1;
      t0++;
      if (done) begin
        tdone.push_back(t0);
        check("b2b_res", result, 32'd123);
      end
    end
    start = 1'b0;
    check("b2b_count", tdone.size() >= 2, 1);
    if (tdone.size() >= 2) check("b2b_spacing", tdone[1] - tdone[0], 35);
    if (tdone.size() >= 3) check("b2b_spacing2", tdone[2] - tdone[1], 35);
    repeat (40) @(posedge clk);

    // Reset in the middle of RUN aborts with everything cleared
    wait_idle();
    src1 = 32'd7; src2 = 32'd9; op = 2'd2; binv = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check_outs("abort", 35'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    do_op(32'd1, 32'd1, 2'd2, 1'b0, lat);
    check("post_rst_lat", lat, 33);
    check_outs("post_rst", {1'b0, 1'b0, 1'b0, 32'd2});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
